// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared constants, ALU encodings and width helpers for cd_param
package cd_pkg;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 10;
    localparam int PORT_HI = 11;
    localparam int PORT_LO = 8;
    localparam int IMM_HI  = 11;
    localparam int IMM_LO  = 4;
    localparam int RA1_HI  = 11;
    localparam int RA1_LO  = 8;
    localparam int RA2_HI  = 7;
    localparam int RA2_LO  = 4;
    localparam int WA3_HI  = 3;
    localparam int WA3_LO  = 0;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_NOT  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NEGA = 3'd6,
        ALU_NEGB = 3'd7
    } alu_op_e;

    function automatic int pidx_width(input int nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

    // One extra bit so the pointer can represent "full" (sp == depth).
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit ALU with zero, negative and carry outputs
module alu
    import cd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       zero,
    output logic       neg,
    output logic       carry
);

    logic [8:0] r;

    always_comb begin
        r = '0;
        case (alu_op_e'(op))
            ALU_PASS: r = {1'b0, a};
            ALU_NOT:  r = {1'b0, ~a};
            ALU_ADD:  r = {1'b0, a} + {1'b0, b};
            ALU_SUB:  r = {1'b0, a} - {1'b0, b};
            ALU_AND:  r = {1'b0, a & b};
            ALU_OR:   r = {1'b0, a | b};
            ALU_NEGA: r = {1'b0, -a};
            ALU_NEGB: r = {1'b0, -b};
            default:  r = {1'b0, a};
        endcase
    end

    assign y     = r[7:0];
    assign carry = r[8];
    assign zero  = (r[7:0] == 8'h00);
    assign neg   = r[7];

endmodule

// File: rtl/memprog.sv
// rtl/memprog.sv - combinational program ROM addressed by the PC
module memprog #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] a,
    output logic [15:0]     rd
);

    // Boot image: port loopback, ALU/flag exercise, call/return and stack walk.
    always_comb begin
        rd = 16'h0000;
        case (a)
            PC_W'('h000): rd = 16'h05C3;
            PC_W'('h001): rd = 16'h0503;
            PC_W'('h002): rd = 16'h0203;
            PC_W'('h003): rd = 16'h03C4;
            PC_W'('h004): rd = 16'h0104;
            PC_W'('h005): rd = 16'h0604;
            PC_W'('h006): rd = 16'h0FF5;
            PC_W'('h007): rd = 16'h0016;
            PC_W'('h008): rd = 16'h0567;
            PC_W'('h009): rd = 16'h0608;
            PC_W'('h00A): rd = 16'h0008;
            PC_W'('h00B): rd = 16'h0010;
            PC_W'('h010): rd = 16'h0100;
            PC_W'('h011): rd = 16'hFC00;
            PC_W'('h017): rd = 16'h03FF;
            default:      rd = 16'h0000;
        endcase
    end

endmodule

// File: rtl/pila_param.sv
// rtl/pila_param.sv - return stack with sticky overflow/underflow detection
module pila_param
    import cd_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wesp,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int SP_W = sp_width(STACK_DEPTH);

    logic [SP_W-1:0] sp, sp_m1;
    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic            do_push, do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign sp_m1   = sp - SP_W'(1);
    assign dout    = mem[sp_m1[AW-1:0]];
    // Pop has priority; a simultaneous push is dropped entirely.
    assign do_pop  = wesp & pop & ~empty;
    assign do_push = wesp & push & ~pop & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_pop) begin
                sp <= sp_m1;
            end else if (do_push) begin
                mem[sp[AW-1:0]] <= din;
                sp              <= sp + SP_W'(1);
            end
            if (wesp & push & ~pop & full) ovf <= 1'b1;
            if (wesp & pop & empty)        unf <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 16 x 8 register file, two read ports, R0 reads as zero
module regfile (
    input  logic       clk,
    input  logic       reset,
    input  logic       we3,
    input  logic [3:0] ra1,
    input  logic [3:0] ra2,
    input  logic [3:0] wa3,
    input  logic [7:0] wd3,
    output logic [7:0] rd1,
    output logic [7:0] rd2
);

    logic [7:0] regs [16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we3) begin
            regs[wa3] <= wd3;
        end
    end

    assign rd1 = (ra1 != 4'd0) ? regs[ra1] : 8'h00;
    assign rd2 = (ra2 != 4'd0) ? regs[ra2] : 8'h00;

endmodule

// File: rtl/cd_param.sv
// rtl/cd_param.sv - parametrised single-cycle datapath; CD_CARRY_EN adds the carry flag
module cd_param
    import cd_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NPORTS-1:0] e_port,
    input  logic                s_inc,
    input  logic                s_inm,
    input  logic                we3,
    input  logic                wez,
    input  logic                wen,
    input  logic                wesp,
    input  logic                push,
    input  logic                pop,
    input  logic                s_inp,
    input  logic                s_outp,
    input  logic [2:0]          op_alu,
    input  logic                wec,
    output logic                s_z,
    output logic                s_n,
    output logic                s_c,
    output logic [8*NPORTS-1:0] s_port,
    output logic [5:0]          opcode,
    output logic                stk_ovf,
    output logic                stk_unf
);

    localparam int         PIDX_W   = pidx_width(NPORTS);
    localparam logic [4:0] NPORTS_L = 5'(NPORTS);

    logic [PC_W-1:0]     pc, pc_next, pc_inc, stk_top;
    logic [15:0]         instr;
    logic [3:0]          port_fld, ra1;
    logic [PIDX_W-1:0]   pidx;
    logic                port_ok, pop_ok, stk_empty, stk_full;
    logic [8*NPORTS-1:0] in_reg;
    logic [7:0]          in_data, rd1, rd2, wd3, alu_y;
    logic                alu_z, alu_n, alu_c;

    memprog #(.PC_W(PC_W)) u_mem (.a(pc), .rd(instr));

    assign opcode   = instr[OPC_HI:OPC_LO];
    assign port_fld = instr[PORT_HI:PORT_LO];
    assign pidx     = port_fld[PIDX_W-1:0];
    assign port_ok  = ({1'b0, port_fld} < NPORTS_L);
    assign in_data  = port_ok ? in_reg[{pidx, 3'b000} +: 8] : 8'h00;
    assign ra1      = s_outp ? instr[WA3_HI:WA3_LO] : instr[RA1_HI:RA1_LO];
    assign wd3      = s_inp ? in_data : (s_inm ? instr[IMM_HI:IMM_LO] : alu_y);

    regfile u_rf (
        .clk (clk),
        .reset(reset),
        .we3 (we3),
        .ra1 (ra1),
        .ra2 (instr[RA2_HI:RA2_LO]),
        .wa3 (instr[WA3_HI:WA3_LO]),
        .wd3 (wd3),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    alu u_alu (.a(rd1), .b(rd2), .op(op_alu), .y(alu_y), .zero(alu_z), .neg(alu_n), .carry(alu_c));

    pila_param #(.STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) u_stack (
        .clk  (clk),
        .reset(reset),
        .wesp (wesp),
        .push (push),
        .pop  (pop),
        .din  (pc_inc),
        .dout (stk_top),
        .empty(stk_empty),
        .full (stk_full),
        .ovf  (stk_ovf),
        .unf  (stk_unf)
    );

    // An underflowing pop falls through to the normal sequencing.
    assign pc_inc  = pc + PC_W'(1);
    assign pop_ok  = wesp & pop & ~stk_empty;
    assign pc_next = pop_ok ? stk_top : (s_inc ? pc_inc : instr[PC_W-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            in_reg <= '0;
            s_z    <= 1'b0;
            s_n    <= 1'b0;
            s_port <= '0;
        end else begin
            pc     <= pc_next;
            in_reg <= e_port;
            if (wez) s_z <= alu_z;
            if (wen) s_n <= alu_n;
            if (s_outp && port_ok) s_port[{pidx, 3'b000} +: 8] <= rd1;
        end
    end

    logic unused_full;
    assign unused_full = stk_full;

`ifdef CD_CARRY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    s_c <= 1'b0;
        else if (wec) s_c <= alu_c;
    end
`else
    logic unused_carry;
    assign s_c          = 1'b0;
    assign unused_carry = ^{wec, alu_c};
`endif

endmodule

// File: tb/tb_cd_param.sv
// tb/tb_cd_param.sv - directed self-checking bench for cd_param
module tb_cd_param;
    import cd_pkg::*;

    localparam int INC = 1, INM = 2, WE = 4, EZ = 8, EN = 16, SP = 32;
    localparam int PSH = 64, POP = 128, INP = 256, OUTP = 512, CW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] e_port_a = 64'h1716A714_13121110;
    logic [31:0] e_port_b = 32'h44332211;
    logic        s_inc = 0, s_inm = 0, we3 = 0, wez = 0, wen = 0, wesp = 0;
    logic        push = 0, pop = 0, s_inp = 0, s_outp = 0, wec = 0;
    logic [2:0]  op_alu = 3'd0;

    logic        s_z_a, s_n_a, s_c_a, ovf_a, unf_a;
    logic        s_z_b, s_n_b, s_c_b, ovf_b, unf_b;
    logic [63:0] s_port_a;
    logic [31:0] s_port_b;
    logic [5:0]  opcode_a, opcode_b;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_c;

    always #5 clk = ~clk;

    cd_param #(.NPORTS(8), .PC_W(10), .STACK_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .e_port(e_port_a),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .wen(wen), .wesp(wesp),
        .push(push), .pop(pop), .s_inp(s_inp), .s_outp(s_outp), .op_alu(op_alu), .wec(wec),
        .s_z(s_z_a), .s_n(s_n_a), .s_c(s_c_a), .s_port(s_port_a), .opcode(opcode_a),
        .stk_ovf(ovf_a), .stk_unf(unf_a)
    );

    cd_param #(.NPORTS(4), .PC_W(10), .STACK_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .e_port(e_port_b),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .wen(wen), .wesp(wesp),
        .push(push), .pop(pop), .s_inp(s_inp), .s_outp(s_outp), .op_alu(op_alu), .wec(wec),
        .s_z(s_z_b), .s_n(s_n_b), .s_c(s_c_b), .s_port(s_port_b), .opcode(opcode_b),
        .stk_ovf(ovf_b), .stk_unf(unf_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic exec(input int ctl, input logic [2:0] op);
        s_inc  = ctl[0];
        s_inm  = ctl[1];
        we3    = ctl[2];
        wez    = ctl[3];
        wen    = ctl[4];
        wesp   = ctl[5];
        push   = ctl[6];
        pop    = ctl[7];
        s_inp  = ctl[8];
        s_outp = ctl[9];
        wec    = ctl[10];
        op_alu = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef CD_CARRY_EN
        exp_c = 1'b1;
`else
        exp_c = 1'b0;
`endif
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_port_a", s_port_a, 64'h0);
        check("rst_flags_a", {s_z_a, s_n_a, s_c_a, ovf_a, unf_a}, 5'b0);
        check("rst_pc", dut_a.pc, 10'h000);
        check("rst_sp", dut_a.u_stack.sp, 0);
        check("rst_opcode", opcode_a, 6'h01);
        reset = 1'b0;

        exec(INC | INM | WE, ALU_PASS);
        exec(INC | INP | WE, ALU_PASS);
        exec(INC | OUTP, ALU_PASS);
        check("inp_out_a", s_port_a, 64'h00000000_00A70000);
        check("inp_oor_b", s_port_b, 32'h0);
        exec(INC | INM | WE, ALU_PASS);
        exec(INC | OUTP, ALU_PASS);
        check("out_p1_a", s_port_a, 64'h00000000_00A73C00);
        check("out_p1_b", s_port_b, 32'h00003C00);
        exec(INC | OUTP, ALU_PASS);
        check("out_p6_a", s_port_a, 64'h003C0000_00A73C00);
        check("out_oor_b", s_port_b, 32'h00003C00);

        exec(INC | INM | WE, ALU_PASS);
        exec(INC | INM | WE, ALU_PASS);
        exec(INC | WE | EZ | EN | CW, ALU_ADD);
        check("add_zn", {s_z_a, s_n_a}, 2'b10);
        check("add_c", s_c_a, exp_c);
        exec(INC | WE | EZ | EN, ALU_NOT);
        check("not_zn", {s_z_a, s_n_a}, 2'b01);
        check("not_c_hold", s_c_a, exp_c);
        exec(INC | OUTP, ALU_PASS);
        check("alu_out_a", s_port_a, 64'h003C0000_00A73CFE);
        check("alu_out_b", s_port_b, 32'h00003CFE);

        exec(0, ALU_PASS);
        check("jump_pc", dut_a.pc, 10'h010);
        exec(SP | PSH, ALU_PASS);
        check("call_pc", dut_a.pc, 10'h100);
        check("call_sp", dut_a.u_stack.sp, 1);
        exec(SP | POP | INC, ALU_PASS);
        check("ret_pc", dut_a.pc, 10'h011);
        check("ret_sp", dut_a.u_stack.sp, 0);
        check("ret_opcode", opcode_a, 6'h3F);

        for (int i = 0; i < 4; i++) exec(SP | PSH | INC, ALU_PASS);
        check("fill_sp", dut_a.u_stack.sp, 4);
        check("fill_ovf", ovf_a, 1'b0);
        exec(SP | PSH | INC, ALU_PASS);
        check("ovf_flag", ovf_a, 1'b1);
        check("ovf_sp", dut_a.u_stack.sp, 4);
        exec(SP | POP | INC, ALU_PASS);
        check("ovf_pop_pc", dut_a.pc, 10'h015);
        check("ovf_pop_sp", dut_a.u_stack.sp, 3);
        for (int i = 0; i < 3; i++) exec(SP | POP | INC, ALU_PASS);
        check("drain_pc", dut_a.pc, 10'h012);
        check("drain_unf", unf_a, 1'b0);
        exec(SP | POP | INC, ALU_PASS);
        check("unf_flag", unf_a, 1'b1);
        check("unf_pc", dut_a.pc, 10'h013);
        check("unf_sp", dut_a.u_stack.sp, 0);
        exec(SP | PSH | INC, ALU_PASS);
        exec(SP | PSH | POP | INC, ALU_PASS);
        check("pushpop_pc", dut_a.pc, 10'h014);
        check("pushpop_sp", dut_a.u_stack.sp, 0);
        check("ovf_sticky", ovf_a, 1'b1);

        for (int i = 0; i < 3; i++) exec(INC, ALU_PASS);
        exec(0, ALU_PASS);
        check("jump_top", dut_a.pc, 10'h3FF);
        exec(INC, ALU_PASS);
        check("pc_wrap", dut_a.pc, 10'h000);

        exec(INC | OUTP, ALU_PASS);
        check("pre_rst_a", s_port_a, 64'h003CA700_00A73CFE);
        check("pre_rst_b", s_port_b, 32'h00003CFE);
        #3 reset = 1'b1;
        #1;
        check("arst_port_a", s_port_a, 64'h0);
        check("arst_port_b", s_port_b, 32'h0);
        check("arst_flags", {s_z_a, s_n_a, s_c_a, ovf_a, unf_a}, 5'b0);
        check("arst_pc", dut_a.pc, 10'h000);
        @(posedge clk);
        #1;
        check("arst_hold_a", s_port_a, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cd_param.md
# cd_param

Parametrised successor of the single-cycle monocycle datapath: the same 8-bit ALU, register file, program memory and PC sequencing, but with a configurable number of I/O ports, a configurable-depth return stack with overflow/underflow detection, and internal output-port address decoding. It sits between the control unit, which supplies decoded control lines and consumes `opcode`, `s_z`, `s_n` and the stack status, and the external port pins.

## Interface
- `NPORTS`, 4: number of input and output ports; power of two, 2..16.
- `PC_W`, 10: program counter and program memory address width.
- `STACK_DEPTH`, 8: return-stack entries; power of two, 2..64.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `e_port` in 8*NPORTS: input ports; port k occupies bits [8k+7:8k].
- `s_inc`, `s_inm`, `we3`, `wez`, `wen`, `wesp`, `push`, `pop`, `s_inp`, `s_outp` in 1 each: control lines, same meaning as the previous datapath.
- `op_alu` in 3: ALU operation.
- `wec` in 1: carry-flag write enable; ignored without `CD_CARRY_EN`.
- `s_z`, `s_n`, `s_c` out 1 each: registered zero, negative and carry flags.
- `s_port` out 8*NPORTS: registered output ports, same packing as `e_port`.
- `opcode` out 6: `instruccion[15:10]`.
- `stk_ovf`, `stk_unf` out 1 each: sticky stack overflow and underflow flags.

## Operation
- Port index `pidx` is the low log2(NPORTS) bits of `instruccion[11:8]`. When `instruccion[11:8]` is NPORTS or greater, the access is out of range.
- Input ports pass through one register each, which is always enabled. `inp` (`s_inp`=1) writes `in_reg[pidx]` to register `instruccion[3:0]`. An out-of-range input reads 0.
- `outp` (`s_outp`=1):
  - `ra1` = `instruccion[3:0]`.
  - `rd1` is written to `s_port[pidx]` only; all other ports hold.
  - An out-of-range output writes nothing.
  - The owe1..owe4 lines are no longer used; decoding is internal.
- Write-data priority: `s_inp` > `s_inm` (immediate `instruccion[11:4]`) > ALU result.
- Next PC:
  - On a valid `pop`, the next PC is the stack top.
  - Otherwise it is `instruccion[PC_W-1:0]` when `s_inc`=0, or PC+1 when `s_inc`=1.
  - PC+1 wraps modulo 2^PC_W.
- Stack, only when `wesp`=1:
  - `push`: store PC+1 at `mem[sp]` and increment `sp`.
  - `pop`: the PC loads `mem[sp-1]` (combinational read) and `sp` decrements.
  - `push` and `pop` together: `pop` wins and `push` is ignored.
  - `push` when `sp`=STACK_DEPTH: no write, `sp` holds, `stk_ovf` is set.
  - `pop` when `sp`=0: the PC takes the normal next-PC, `sp` holds, `stk_unf` is set.
  - `stk_ovf` and `stk_unf` stay set until reset.
- Flags: `s_z` and `s_n` load the ALU zero and negative outputs when `wez` or `wen` is 1, respectively.

## Timing
- Reset values: PC=0, `sp`=0, all `s_port`=0, input registers 0, `s_z`=`s_n`=`s_c`=0, `stk_ovf`=`stk_unf`=0.
- Reset asserted mid-instruction aborts the instruction; no partial write survives.
- Every instruction completes in one cycle. Register file, ports, flags, stack and PC all update on the same edge.
- Input latency: a value present on `e_port` at edge k is visible to an `inp` executing in cycle k+1.
- Output latency: `s_port` changes on the edge that ends the `outp` cycle.
- The program memory read is combinational in the PC, as in the existing `memprog`.

## Configuration
- `CD_CARRY_EN` defined:
  - `s_c` is a flip-flop loaded from the ALU carry when `wec`=1.
- `CD_CARRY_EN` undefined:
  - No carry flop is built.
  - `s_c` is tied to 0.
  - `wec` is ignored.

## Structure
- Package `cd_pkg` holds:
  - instruction field positions (opcode [15:10], port index [11:8], immediate [11:4], register fields);
  - `op_alu` encodings;
  - `clog2`-based width constants for `pidx` and `sp`.
- Sub-module `pila_param` holds:
  - parameters `STACK_DEPTH` and `PC_W`;
  - ports `clk`, `reset`, `wesp`, `push`, `pop`, `din`, `dout`, `empty`, `full`, `ovf`, `unf`.
- `memprog` takes `#(PC_W)`.
- `regfile`, `alu`, `registro`, `ffd` and `sum` are reused unchanged.

## Test plan
- **Input port:** NPORTS=8; drive `e_port` port 5 = 8'hA7, then `inp` with port 5 and destination R3, followed by `outp` of R3 to port 2. Expect `s_port` port 2 = 8'hA7 one edge later and all other ports 0.
- **Out of range:** NPORTS=4; `outp` with `instruccion[11:8]`=6. Expect no port change. `inp` from index 6 writes 0.
- **Call and return:** STACK_DEPTH=4; push at PC=10'h010 with jump to 10'h100, then `pop`. Expect PC=10'h011 and `sp` back to 0.
- **Overflow:** five pushes with STACK_DEPTH=4. Expect `stk_ovf`=1 after the 5th push and `sp`=4. A following `pop` returns the 4th pushed address.
- **Underflow and simultaneous ops:** `pop` at `sp`=0 gives `stk_unf`=1 and PC=PC+1 (`s_inc`=1). `push` and `pop` together perform only the pop.
- **Async reset:** assert `reset` mid-cycle after a port write. Expect all outputs 0 immediately and PC=0. With `CD_CARRY_EN`, adding 8'hFF + 8'h01 with `wec`=1 gives `s_c`=1 and `s_z`=1.
